fpu_req_arbiter: RTL and testbench

- Shares one CVFPU instance between NUM_REQ requesters, e.g. several issue ports or test agents.
- Arbitrates requests round-robin and retags each accepted request with an internal transaction ID from a free-tag pool.
- Records the owner and original transaction ID per tag, and routes each FPU response back to its owner with the original ID restored.
- Sits between the requesters and the FPU request/response ports.

---
 rtl/fpu_req_arbiter_pkg.sv | 58 +++++
 rtl/fpu_tag_pool.sv | 52 +++++
 rtl/fpu_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fpu_req_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_req_arbiter_pkg.sv
// Shared types for the FPU request arbiter: FU request payload, exception record,
// tag-table entry and the round-robin pick helper.
package fpu_req_arbiter_pkg;

  localparam int unsigned FLen        = 64;
  localparam int unsigned XLen        = 64;
  localparam int unsigned TransIdBits = 3;
  localparam int unsigned ArbMaxReq   = 8;
  localparam int unsigned ArbReqIdxW  = 3;

  typedef enum logic [3:0] {
    FAdd, FSub, FMul, FDiv, FMadd, FSqrt, FCmp, FCvt
  } fpu_op_t;

  typedef struct packed {
    fpu_op_t                operation;
    logic [FLen-1:0]        operand_a;
    logic [FLen-1:0]        operand_b;
    logic [FLen-1:0]        operand_c;
    logic [TransIdBits-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    logic [XLen-1:0] cause;
    logic [XLen-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [ArbReqIdxW-1:0]  owner;
    logic [TransIdBits-1:0] orig_id;
  } arb_tag_entry_t;

  typedef struct packed {
    logic                  found;
    logic [ArbReqIdxW-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or above ptr, wrapping within num_req requesters.
  function automatic rr_pick_t rr_pick(input logic [ArbMaxReq-1:0]  valid,
                                       input logic [ArbReqIdxW-1:0] ptr,
                                       input int unsigned           num_req);
    rr_pick_t              res;
    logic [ArbReqIdxW-1:0] j;
    res = '0;
    for (int unsigned i = 0; i < ArbMaxReq; i++) begin
      if (i < num_req) begin
        j = ArbReqIdxW'((32'(ptr) + i) % num_req);
        if (!res.found && valid[j]) begin
          res.found = 1'b1;
          res.idx   = j;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fpu_tag_pool.sv
// Free-tag pool: busy bitmask, lowest-free-tag encoder and an in-use counter.
module fpu_tag_pool #(
  parameter int unsigned TAG_W = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                alloc_i,
  input  logic                free_i,
  input  logic [TAG_W-1:0]    free_tag_i,
  output logic [TAG_W-1:0]    alloc_tag_o,
  output logic                avail_o,
  output logic [2**TAG_W-1:0] busy_o,
  output logic [TAG_W:0]      count_o
);

  localparam int NTags = 2**TAG_W;

  logic [NTags-1:0] r_busy;
  logic [TAG_W:0]   r_count;

  // Lowest-index free tag; scanning downward lets the lowest one win.
  always_comb begin
    alloc_tag_o = '0;
    avail_o     = 1'b0;
    for (int i = NTags - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        avail_o     = 1'b1;
        alloc_tag_o = TAG_W'(i);
      end
    end
  end

  // Busy mask and count; the allocated tag is always free and the freed tag always busy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      if (alloc_i) r_busy[alloc_tag_o] <= 1'b1;
      if (free_i)  r_busy[free_tag_i]  <= 1'b0;
      case ({alloc_i, free_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign busy_o  = r_busy;
  assign count_o = r_count;

endmodule

// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one FPU between requesters; retags requests from a
// free-tag pool and routes responses back to their owner with the original ID.
module fpu_req_arbiter
  import fpu_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned TAG_W     = TransIdBits,
  parameter int unsigned REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  fu_data_t [NUM_REQ-1:0]            req_data_i,
  input  logic [NUM_REQ-1:0][1:0]           req_fmt_i,
  input  logic [NUM_REQ-1:0][2:0]           req_rm_i,
  input  logic [NUM_REQ-1:0][6:0]           req_prec_i,
  output logic                              fpu_valid_o,
  input  logic                              fpu_ready_i,
  output fu_data_t                          fpu_data_o,
  output logic [1:0]                        fpu_fmt_o,
  output logic [2:0]                        fpu_rm_o,
  output logic [2:0]                        fpu_frm_o,
  output logic [6:0]                        fpu_prec_o,
  input  logic                              fpu_rsp_valid_i,
  input  logic [TAG_W-1:0]                  fpu_rsp_tag_i,
  input  logic [FLen-1:0]                   fpu_rsp_result_i,
  input  exception_t                        fpu_rsp_exc_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [TAG_W-1:0]                  rsp_trans_id_o,
  output logic [FLen-1:0]                   rsp_result_o,
  output exception_t                        rsp_exc_o,
  output logic [TAG_W:0]                    outstanding_o,
  output logic                              busy_o,
  output logic                              spurious_o
);

  localparam int unsigned NTags = 2**TAG_W;

  logic [REQ_IDX_W-1:0] r_rr_ptr;
  arb_tag_entry_t       r_table [NTags];
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [TAG_W-1:0]     r_rsp_id;
  logic [FLen-1:0]      r_rsp_result;
  exception_t           r_rsp_exc;
  logic                 r_spurious;

  rr_pick_t             w_pick;
  logic                 w_accept;
  logic [TAG_W-1:0]     w_alloc_tag;
  logic                 w_avail;
  logic [NTags-1:0]     w_busy_mask;
  logic                 w_rsp_hit;
  arb_tag_entry_t       w_rsp_entry;
  fu_data_t             w_sel_data;
  logic [1:0]           w_sel_fmt;
  logic [2:0]           w_sel_rm;
  logic [6:0]           w_sel_prec;
  logic [REQ_IDX_W-1:0] w_rr_next;

  assign w_pick = rr_pick(ArbMaxReq'(req_valid_i), ArbReqIdxW'(r_rr_ptr), NUM_REQ);

  // Nothing is offered while reset is held so all handshake outputs read 0 at once.
  assign fpu_valid_o = w_pick.found & w_avail & ~rst_i;
  assign w_accept    = fpu_valid_o & fpu_ready_i;

  // Mux the granted requester onto the FPU side and derive ready and next pointer.
  always_comb begin
    w_sel_data  = '0;
    w_sel_fmt   = '0;
    w_sel_rm    = '0;
    w_sel_prec  = '0;
    req_ready_o = '0;
    w_rr_next   = r_rr_ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_pick.idx == ArbReqIdxW'(i)) begin
        w_sel_data     = req_data_i[i];
        w_sel_fmt      = req_fmt_i[i];
        w_sel_rm       = req_rm_i[i];
        w_sel_prec     = req_prec_i[i];
        req_ready_o[i] = w_accept;
        w_rr_next      = (i == NUM_REQ - 1) ? '0 : REQ_IDX_W'(i + 1);
      end
    end
  end

  // Forward the granted request with its trans_id replaced by the allocated tag.
  always_comb begin
    fpu_data_o          = w_sel_data;
    fpu_data_o.trans_id = TransIdBits'(w_alloc_tag);
  end

  assign fpu_fmt_o  = w_sel_fmt;
  assign fpu_rm_o   = w_sel_rm;
  assign fpu_frm_o  = 3'b000;
  assign fpu_prec_o = w_sel_prec;

  fpu_tag_pool #(
    .TAG_W (TAG_W)
  ) u_tag_pool (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alloc_i     (w_accept),
    .free_i      (w_rsp_hit),
    .free_tag_i  (fpu_rsp_tag_i),
    .alloc_tag_o (w_alloc_tag),
    .avail_o     (w_avail),
    .busy_o      (w_busy_mask),
    .count_o     (outstanding_o)
  );

  assign w_rsp_hit   = fpu_rsp_valid_i & w_busy_mask[fpu_rsp_tag_i];
  assign w_rsp_entry = r_table[fpu_rsp_tag_i];

  // Round-robin pointer advances past the winner only on acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_rr_next;
    end
  end

  // Tag table: owner and original ID of each allocated tag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NTags; i++) r_table[i] <= '0;
    end else if (w_accept) begin
      r_table[w_alloc_tag] <= '{owner: w_pick.idx, orig_id: w_sel_data.trans_id};
    end
  end

  // Response registers: one-cycle strobe to the owner, or a spurious pulse for a free tag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid  <= '0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_exc    <= '0;
      r_spurious   <= 1'b0;
    end else begin
      r_spurious <= fpu_rsp_valid_i & ~w_busy_mask[fpu_rsp_tag_i];
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        r_rsp_valid[i] <= w_rsp_hit & (w_rsp_entry.owner == ArbReqIdxW'(i));
      end
      if (w_rsp_hit) begin
        r_rsp_id     <= TAG_W'(w_rsp_entry.orig_id);
        r_rsp_result <= fpu_rsp_result_i;
        r_rsp_exc    <= fpu_rsp_exc_i;
      end
    end
  end

  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_trans_id_o = r_rsp_id;
  assign rsp_result_o   = r_rsp_result;
  assign rsp_exc_o      = r_rsp_exc;
  assign spurious_o     = r_spurious;
  assign busy_o         = (outstanding_o != '0);

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter: 2 requesters, 8 tags.
module tb_fpu_req_arbiter;
  import fpu_req_arbiter_pkg::*;

  localparam int unsigned NumReq = 2;
  localparam int unsigned TagW   = 3;

  logic                     clk;
  logic                     rst;
  logic [NumReq-1:0]        req_valid;
  logic [NumReq-1:0]        req_ready;
  fu_data_t [NumReq-1:0]    req_data;
  logic [NumReq-1:0][1:0]   req_fmt;
  logic [NumReq-1:0][2:0]   req_rm;
  logic [NumReq-1:0][6:0]   req_prec;
  logic                     fpu_valid;
  logic                     fpu_ready;
  fu_data_t                 fpu_data;
  logic [1:0]               fpu_fmt;
  logic [2:0]               fpu_rm;
  logic [2:0]               fpu_frm;
  logic [6:0]               fpu_prec;
  logic                     fpu_rsp_valid;
  logic [TagW-1:0]          fpu_rsp_tag;
  logic [FLen-1:0]          fpu_rsp_result;
  exception_t               fpu_rsp_exc;
  logic [NumReq-1:0]        rsp_valid;
  logic [TagW-1:0]          rsp_trans_id;
  logic [FLen-1:0]          rsp_result;
  exception_t               rsp_exc;
  logic [TagW:0]            outstanding;
  logic                     busy;
  logic                     spurious;

  int n_checks = 0;
  int n_errs   = 0;

  fpu_req_arbiter #(
    .NUM_REQ (NumReq),
    .TAG_W   (TagW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_data_i       (req_data),
    .req_fmt_i        (req_fmt),
    .req_rm_i         (req_rm),
    .req_prec_i       (req_prec),
    .fpu_valid_o      (fpu_valid),
    .fpu_ready_i      (fpu_ready),
    .fpu_data_o       (fpu_data),
    .fpu_fmt_o        (fpu_fmt),
    .fpu_rm_o         (fpu_rm),
    .fpu_frm_o        (fpu_frm),
    .fpu_prec_o       (fpu_prec),
    .fpu_rsp_valid_i  (fpu_rsp_valid),
    .fpu_rsp_tag_i    (fpu_rsp_tag),
    .fpu_rsp_result_i (fpu_rsp_result),
    .fpu_rsp_exc_i    (fpu_rsp_exc),
    .rsp_valid_o      (rsp_valid),
    .rsp_trans_id_o   (rsp_trans_id),
    .rsp_result_o     (rsp_result),
    .rsp_exc_o        (rsp_exc),
    .outstanding_o    (outstanding),
    .busy_o           (busy),
    .spurious_o       (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = '0;
    req_data       = '0;
    req_fmt        = '0;
    req_rm         = '0;
    req_prec       = '0;
    fpu_ready      = 1'b0;
    fpu_rsp_valid  = 1'b0;
    fpu_rsp_tag    = '0;
    fpu_rsp_result = '0;
    fpu_rsp_exc    = '0;
    req_data[0].operand_a = 64'hA0;
    req_data[1].operand_a = 64'hB1;
    req_fmt[1]  = 2'd2;
    req_rm[1]   = 3'd3;
    req_prec[1] = 7'd32;

    // Reset state
    tick();
    tick();
    check_eq("rst_outstanding", 64'(outstanding), 64'd0);
    check_eq("rst_busy",        64'(busy),        64'd0);
    check_eq("rst_rsp_valid",   64'(rsp_valid),   64'd0);
    check_eq("rst_spurious",    64'(spurious),    64'd0);
    check_eq("rst_fpu_valid",   64'(fpu_valid),   64'd0);
    rst = 1'b0;

    // Single request: req0 id 5 gets tag 0, response restores id 5
    req_data[0].trans_id = 3'd5;
    req_valid = 2'b01;
    fpu_ready = 1'b1;
    #1;
    check_eq("single_fpu_valid", 64'(fpu_valid),         64'd1);
    check_eq("single_tag",       64'(fpu_data.trans_id), 64'd0);
    check_eq("single_ready",     64'(req_ready),         64'b01);
    check_eq("single_opa",       64'(fpu_data.operand_a), 64'hA0);
    tick();
    req_valid = 2'b00;
    check_eq("single_outst1", 64'(outstanding), 64'd1);
    check_eq("single_busy",   64'(busy),        64'd1);
    fpu_rsp_valid     = 1'b1;
    fpu_rsp_tag       = 3'd0;
    fpu_rsp_result    = 64'h3F80_0000;
    fpu_rsp_exc       = '0;
    fpu_rsp_exc.valid = 1'b1;
    tick();
    fpu_rsp_valid = 1'b0;
    check_eq("single_rsp_valid", 64'(rsp_valid),      64'b01);
    check_eq("single_rsp_id",    64'(rsp_trans_id),   64'd5);
    check_eq("single_rsp_res",   rsp_result,          64'h3F80_0000);
    check_eq("single_rsp_exc",   64'(rsp_exc.valid),  64'd1);
    check_eq("single_outst0",    64'(outstanding),    64'd0);
    tick();
    check_eq("single_strobe_once", 64'(rsp_valid), 64'b00);

    // Fairness: last winner was req0 so req1 goes first; tags 0..7 in order
    req_data[0].trans_id = 3'd2;
    req_data[1].trans_id = 3'd6;
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq($sformatf("fair_tag%0d", i),   64'(fpu_data.trans_id), 64'(i));
      check_eq($sformatf("fair_ready%0d", i), 64'(req_ready),         64'(1 << ((i + 1) % 2)));
      tick();
    end

    // Pool exhausted: stall
    #1;
    check_eq("full_fpu_valid", 64'(fpu_valid),   64'd0);
    check_eq("full_ready",     64'(req_ready),   64'd0);
    check_eq("full_outst",     64'(outstanding), 64'd8);

    // Free tag 2 (owner req1, id 6); not reusable in the same cycle
    fpu_rsp_valid  = 1'b1;
    fpu_rsp_tag    = 3'd2;
    fpu_rsp_result = 64'h4;
    #1;
    check_eq("free_no_bypass", 64'(fpu_valid), 64'd0);
    tick();
    fpu_rsp_valid = 1'b0;
    check_eq("free_rsp_valid", 64'(rsp_valid),    64'b10);
    check_eq("free_rsp_id",    64'(rsp_trans_id), 64'd6);
    check_eq("free_outst",     64'(outstanding),  64'd7);
    #1;
    check_eq("realloc_valid", 64'(fpu_valid),         64'd1);
    check_eq("realloc_tag",   64'(fpu_data.trans_id), 64'd2);
    check_eq("realloc_ready", 64'(req_ready),         64'b10);
    req_valid = 2'b00;  // drop before acceptance
    #1;
    check_eq("drop_fpu_valid", 64'(fpu_valid), 64'd0);

    // Out-of-order: tag 1 (req0, id 2) then tag 0 (req1, id 6), then spurious tag 2
    fpu_rsp_valid  = 1'b1;
    fpu_rsp_tag    = 3'd1;
    fpu_rsp_result = 64'h1111;
    tick();
    fpu_rsp_tag    = 3'd0;
    fpu_rsp_result = 64'h2222;
    check_eq("ooo1_valid", 64'(rsp_valid),    64'b01);
    check_eq("ooo1_id",    64'(rsp_trans_id), 64'd2);
    check_eq("ooo1_res",   rsp_result,        64'h1111);
    tick();
    fpu_rsp_tag    = 3'd2;
    fpu_rsp_result = 64'h3333;
    check_eq("ooo2_valid", 64'(rsp_valid),    64'b10);
    check_eq("ooo2_id",    64'(rsp_trans_id), 64'd6);
    check_eq("ooo2_res",   rsp_result,        64'h2222);
    tick();
    fpu_rsp_valid = 1'b0;
    check_eq("spur_pulse",  64'(spurious),    64'd1);
    check_eq("spur_strobe", 64'(rsp_valid),   64'b00);
    check_eq("spur_outst",  64'(outstanding), 64'd5);
    tick();
    check_eq("spur_once", 64'(spurious), 64'd0);

    // Reset mid-flight with 5 tags outstanding
    req_valid = 2'b11;
    fpu_ready = 1'b0;
    #1;
    check_eq("pre_rst_valid", 64'(fpu_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_fpu_valid", 64'(fpu_valid),   64'd0);
    check_eq("arst_outst",     64'(outstanding), 64'd0);
    check_eq("arst_busy",      64'(busy),        64'd0);
    check_eq("arst_ready",     64'(req_ready),   64'd0);
    tick();
    tick();
    rst       = 1'b0;
    fpu_ready = 1'b1;
    #1;
    check_eq("post_rst_ready", 64'(req_ready),          64'b01);
    check_eq("post_rst_tag",   64'(fpu_data.trans_id),  64'd0);
    check_eq("post_rst_opa",   64'(fpu_data.operand_a), 64'hA0);
    tick();

    // Backpressure: req1 held for 3 cycles, pointer must stay on req1
    fpu_ready = 1'b0;
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("bp_ready%0d", i), 64'(req_ready), 64'd0);
      tick();
    end
    req_valid = 2'b11;
    #1;
    check_eq("bp_ptr_kept", 64'(fpu_data.operand_a), 64'hB1);
    fpu_ready = 1'b1;
    #1;
    check_eq("bp_ready_go", 64'(req_ready),         64'b10);
    check_eq("bp_tag",      64'(fpu_data.trans_id), 64'd1);
    check_eq("bp_fmt",      64'(fpu_fmt),           64'd2);
    check_eq("bp_rm",       64'(fpu_rm),            64'd3);
    check_eq("bp_prec",     64'(fpu_prec),          64'd32);
    check_eq("bp_frm",      64'(fpu_frm),           64'd0);
    tick();
    req_valid = 2'b00;
    check_eq("bp_outst", 64'(outstanding), 64'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
